// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Optional DCACHE_STATS_EN adds saturating hit/miss counters.
module data_cache #(
    parameter int SET_BITS   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [3:0]            i_byte_en,
    input  logic [31:0]           i_wdata,
    input  logic                  i_flush,
    output logic [31:0]           o_rdata,
    output logic                  o_done,
    output logic                  o_busy,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic [31:0]           o_mem_wdata,
    output logic [3:0]            o_mem_byte_en,
    input  logic [31:0]           i_mem_rdata,
    input  logic                  i_mem_ready,
    output logic [31:0]           o_hit_count,
    output logic [31:0]           o_miss_count
);
    localparam int LINES = 1 << SET_BITS;
    localparam int TAG_W = ADDR_WIDTH - SET_BITS - 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_WRITE,
        S_RESPOND
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [31:0]       data_q [LINES][4];

    logic [SET_BITS-1:0] idx;
    logic [1:0]          woff;
    logic [TAG_W-1:0]    tag;
    logic                lookup_hit;
    logic                apply_flush;
    logic                hit_ev, miss_ev;
    logic                beat, line_fill, wr_hit;
    logic [31:0]         wr_merge;
    logic                unused_addr;

    assign idx  = i_address[SET_BITS+3:4];
    assign woff = i_address[3:2];
    assign tag  = i_address[ADDR_WIDTH-1:SET_BITS+4];
    assign unused_addr = ^i_address[1:0];

    // A same-cycle flush wins over the lookup, so the request sees a miss.
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag) && !i_flush;

    // Store data merged into the currently cached word.
    always_comb begin
        wr_merge = data_q[idx][woff];
        for (int b = 0; b < 4; b++) begin
            if (i_byte_en[b]) wr_merge[8*b +: 8] = i_wdata[8*b +: 8];
        end
    end

    // Next-state, memory port and bookkeeping decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        flush_pend_d  = flush_pend_q;
        valid_d       = valid_q;
        apply_flush   = 1'b0;
        hit_ev        = 1'b0;
        miss_ev       = 1'b0;
        beat          = 1'b0;
        line_fill     = 1'b0;
        wr_hit        = 1'b0;
        o_mem_read    = 1'b0;
        o_mem_write   = 1'b0;
        o_mem_address = '0;
        o_mem_wdata   = '0;
        o_mem_byte_en = '0;
        unique case (state_q)
            S_IDLE: begin
                apply_flush = i_flush;
                if (i_write) begin
                    state_d = (i_byte_en == 4'd0) ? S_RESPOND : S_WRITE;
                    if (lookup_hit) begin
                        hit_ev = 1'b1;
                        wr_hit = 1'b1;
                    end else begin
                        miss_ev = 1'b1;
                    end
                end else if (i_read) begin
                    if (lookup_hit) begin
                        hit_ev  = 1'b1;
                        rdata_d = data_q[idx][woff];
                        state_d = S_RESPOND;
                    end else begin
                        miss_ev = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                o_mem_read    = 1'b1;
                o_mem_address = {i_address[ADDR_WIDTH-1:4], cnt_q, 2'b00};
                if (i_mem_ready) begin
                    beat  = 1'b1;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == woff) rdata_d = i_mem_rdata;
                    if (cnt_q == 2'd3) begin
                        line_fill = 1'b1;
                        state_d   = S_RESPOND;
                    end
                end
            end
            S_WRITE: begin
                o_mem_write   = 1'b1;
                o_mem_address = {i_address[ADDR_WIDTH-1:2], 2'b00};
                o_mem_wdata   = i_wdata;
                o_mem_byte_en = i_byte_en;
                if (i_mem_ready) state_d = S_RESPOND;
            end
            S_RESPOND: begin
                state_d     = S_IDLE;
                apply_flush = flush_pend_q || i_flush;
            end
        endcase
        if (i_flush && (state_q == S_REFILL || state_q == S_WRITE)) begin
            flush_pend_d = 1'b1;
        end
        if (apply_flush) flush_pend_d = 1'b0;
        if (line_fill) valid_d[idx] = 1'b1;
        if (apply_flush) valid_d = '0;
    end

    // Control state with synchronous reset; aborts any memory request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            rdata_q      <= rdata_d;
        end
    end

    // Line storage: refill beats, store-hit merges and tag capture.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (beat) data_q[idx][cnt_q] <= i_mem_rdata;
            if (wr_hit) data_q[idx][woff] <= wr_merge;
            if (line_fill) tag_q[idx] <= tag;
        end
    end

    assign o_rdata = rdata_q;
    assign o_done  = (state_q == S_RESPOND);
    assign o_busy  = (state_q != S_IDLE);

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_q, hit_d, miss_q, miss_d;

    // Saturating counters, cleared together with the valid bits.
    always_comb begin
        hit_d  = apply_flush ? 32'd0 : hit_q;
        miss_d = apply_flush ? 32'd0 : miss_q;
        if (hit_ev && hit_d != 32'hFFFF_FFFF) hit_d = hit_d + 32'd1;
        if (miss_ev && miss_d != 32'hFFFF_FFFF) miss_d = miss_d + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hit_q  <= 32'd0;
            miss_q <= 32'd0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign o_hit_count  = hit_q;
    assign o_miss_count = miss_q;
`else
    logic unused_stats;
    assign unused_stats = hit_ev ^ miss_ev;
    assign o_hit_count  = 32'd0;
    assign o_miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: random and directed loads/stores
// checked against a line-level reference model and a backing memory.
module tb_data_cache;
    logic        clk;
    logic        i_reset, i_read, i_write, i_flush;
    logic [31:0] i_address, i_wdata, i_mem_rdata;
    logic [3:0]  i_byte_en;
    logic        i_mem_ready;
    logic [31:0] o_rdata, o_mem_address, o_mem_wdata;
    logic        o_done, o_busy, o_mem_read, o_mem_write;
    logic [3:0]  o_mem_byte_en;
    logic [31:0] o_hit_count, o_miss_count;

    data_cache #(.SET_BITS(4), .ADDR_WIDTH(32)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_read(i_read),
        .i_write(i_write), .i_address(i_address),
        .i_byte_en(i_byte_en), .i_wdata(i_wdata), .i_flush(i_flush),
        .o_rdata(o_rdata), .o_done(o_done), .o_busy(o_busy),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_address(o_mem_address), .o_mem_wdata(o_mem_wdata),
        .o_mem_byte_en(o_mem_byte_en), .i_mem_rdata(i_mem_rdata),
        .i_mem_ready(i_mem_ready), .o_hit_count(o_hit_count),
        .o_miss_count(o_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [31:0] rdata;
        int          nrd;
        logic [31:0] line;
        bit          wr;
        logic [31:0] waddr, wdata;
        logic [3:0]  wbe;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_log[$];
    logic [31:0] wa_log[$], wd_log[$];
    logic [3:0]  wb_log[$];
    logic [31:0] mem [int unsigned];
    bit          mv [16];
    int unsigned mt [16];
    int          nhit, nmiss;
    int          stall_n;
    int          checks, errors;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int unsigned k;
        k = {a[31:2], 2'b00};
        if (mem.exists(k)) return mem[k];
        return (k * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
        logic [31:0] w;
        w = mem_rd(a);
        for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        mem[{a[31:2], 2'b00}] = w;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 16; i++) mv[i] = 0;
        nhit = 0;
        nmiss = 0;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wa_log.delete();
        wd_log.delete();
        wb_log.delete();
    endtask

    // Memory responder: stalls stall_n cycles per beat, serves from mem.
    initial begin
        int wcnt;
        wcnt = 0;
        i_mem_ready = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            i_mem_ready = 1'b0;
            if (o_mem_read || o_mem_write) begin
                if (wcnt < stall_n) begin
                    wcnt++;
                    i_mem_rdata = $urandom;
                end else begin
                    wcnt = 0;
                    i_mem_ready = 1'b1;
                    if (o_mem_read) begin
                        i_mem_rdata = mem_rd(o_mem_address);
                        rd_log.push_back(o_mem_address);
                    end else begin
                        wa_log.push_back(o_mem_address);
                        wd_log.push_back(o_mem_wdata);
                        wb_log.push_back(o_mem_byte_en);
                    end
                end
            end else begin
                wcnt = 0;
                i_mem_ready = ($urandom_range(0, 3) == 0);
                i_mem_rdata = $urandom;
            end
        end
    end

    // Monitor: every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        int n;
        if (!i_reset && o_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (e.is_read) chk("rdata", o_rdata, e.rdata);
                chk("rd_beats", 32'(rd_log.size()), 32'(e.nrd));
                n = (rd_log.size() < e.nrd) ? rd_log.size() : e.nrd;
                for (int i = 0; i < n; i++)
                    chk("rd_addr", rd_log[i], e.line + 32'(4 * i));
                chk("wr_beats", 32'(wa_log.size()), e.wr ? 32'd1 : 32'd0);
                if (e.wr && wa_log.size() == 1) begin
                    chk("wr_addr", wa_log[0], e.waddr);
                    chk("wr_data", wd_log[0], e.wdata);
                    chk("wr_be", 32'(wb_log[0]), 32'(e.wbe));
                end
            end
            clear_logs();
        end
    end

    task automatic do_flush();
        @(negedge clk);
        i_flush = 1'b1;
        model_flush();
        @(negedge clk);
        i_flush = 1'b0;
    endtask

    task automatic do_req(input bit wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] d,
                          input bit fl_now, input int fl_at_in);
        exp_t e;
        bit hit, short_op, done;
        int idx, lat, fl_at;
        int unsigned tg;
        idx = int'((a >> 4) & 32'hF);
        tg = a >> 8;
        if (fl_now) model_flush();
        hit = mv[idx] && (mt[idx] == tg);
        if (hit) nhit++;
        else nmiss++;
        short_op = wr ? (be == 4'd0) : hit;
        fl_at = short_op ? -1 : fl_at_in;
        e.is_read = !wr;
        e.line = {a[31:4], 4'h0};
        e.waddr = {a[31:2], 2'b00};
        e.wdata = d;
        e.wbe = be;
        e.rdata = '0;
        if (wr) begin
            e.nrd = 0;
            e.wr = (be != 4'd0);
            if (be != 4'd0) mem_wr(a, d, be);
        end else begin
            e.nrd = hit ? 0 : 4;
            e.wr = 0;
            e.rdata = mem_rd(a);
            mv[idx] = 1;
            mt[idx] = tg;
        end
        exp_q.push_back(e);
        @(negedge clk);
        i_read = !wr;
        i_write = wr;
        i_address = a;
        i_byte_en = be;
        i_wdata = d;
        i_flush = fl_now;
        lat = 0;
        done = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            i_flush = (lat == fl_at);
            if (o_done) done = 1;
        end
        i_read = 1'b0;
        i_write = 1'b0;
        i_flush = 1'b0;
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        if (short_op) chk("latency", 32'(lat), 32'd1);
        if (fl_at > 0) model_flush();
    endtask

    task automatic chk_stats(input string tag);
`ifdef DCACHE_STATS_EN
        chk({tag, "_hits"}, o_hit_count, 32'(nhit));
        chk({tag, "_misses"}, o_miss_count, 32'(nmiss));
`else
        chk({tag, "_hits"}, o_hit_count, 32'd0);
        chk({tag, "_misses"}, o_miss_count, 32'd0);
`endif
    endtask

    initial begin
        int t;
        logic [31:0] a;
        checks = 0;
        errors = 0;
        stall_n = 0;
        i_reset = 1'b1;
        i_read = 1'b0;
        i_write = 1'b0;
        i_flush = 1'b0;
        i_address = '0;
        i_byte_en = '0;
        i_wdata = '0;
        model_flush();
        for (int i = 0; i < 4; i++) mem[32'h100 + 4 * i] = 32'hA0 + i;

        repeat (3) @(negedge clk);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_memrw", {30'd0, o_mem_read, o_mem_write}, 32'd0);
        chk("rst_addr", o_mem_address, 32'd0);
        chk("rst_wdata", o_mem_wdata, 32'd0);
        chk("rst_be", {28'd0, o_mem_byte_en}, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk_stats("rst");
        i_reset = 1'b0;

        stall_n = 2;
        do_req(0, 32'h104, 4'h0, 0, 0, -1);
        stall_n = 1;
        do_req(0, 32'h10C, 4'h0, 0, 0, -1);
        do_req(1, 32'h104, 4'b0011, 32'hDEAD_BEEF, 0, -1);
        do_req(0, 32'h104, 4'h0, 0, 0, -1);
        do_req(1, 32'h2000, 4'hF, 32'h1234_5678, 0, -1);
        do_req(0, 32'h2000, 4'h0, 0, 0, -1);
        do_req(0, 32'h100, 4'h0, 0, 0, -1);
        do_req(0, 32'h500, 4'h0, 0, 0, -1);
        do_req(0, 32'h100, 4'h0, 0, 0, -1);

        do_req(0, 32'h300, 4'h0, 0, 0, 1);
        do_req(0, 32'h300, 4'h0, 0, 0, -1);
        chk_stats("flush_miss");

        // Reset while the second refill beat is outstanding.
        stall_n = 2;
        @(negedge clk);
        i_read = 1'b1;
        i_address = 32'h700;
        t = 0;
        while (rd_log.size() < 1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("beat1_timeout", 32'd0, 32'd1);
        @(negedge clk);
        i_reset = 1'b1;
        i_read = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_memrd", {31'd0, o_mem_read}, 32'd0);
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_done", {31'd0, o_done}, 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        model_flush();
        repeat (3) @(negedge clk);
        clear_logs();
        do_req(0, 32'h700, 4'h0, 0, 0, -1);
        do_req(0, 32'h704, 4'h0, 0, 0, -1);

        for (int n = 0; n < 200; n++) begin
            stall_n = $urandom_range(0, 2);
            a = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4)
                    | ($urandom_range(0, 3) << 2));
            t = $urandom_range(0, 99);
            if (t < 8) begin
                do_flush();
            end else if (t < 55) begin
                do_req(0, a, 4'h0, 0, ($urandom_range(0, 19) == 0),
                       ($urandom_range(0, 9) == 0) ? 1 : -1);
            end else begin
                do_req(1, a, 4'($urandom_range(0, 15)), $urandom,
                       ($urandom_range(0, 19) == 0),
                       ($urandom_range(0, 9) == 0) ? 1 : -1);
            end
        end
        repeat (3) @(negedge clk);
        chk_stats("final");
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
